// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: op_type codes, FSM/owner encodings and op classification shared by the memory port logic.
package mem_port_arbiter_pkg;
    localparam logic [5:0] OP_LB  = 6'h10;
    localparam logic [5:0] OP_LH  = 6'h11;
    localparam logic [5:0] OP_LW  = 6'h12;
    localparam logic [5:0] OP_LBU = 6'h13;
    localparam logic [5:0] OP_LHU = 6'h14;
    localparam logic [5:0] OP_SB  = 6'h18;
    localparam logic [5:0] OP_SH  = 6'h19;
    localparam logic [5:0] OP_SW  = 6'h1A;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;
    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction
    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane strobes/replicated write data for stores and extract/extend for loads.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);
    logic [15:0] lo;
    // Bytes above the word fall off the shift, so a halfword at offset 3 gets a zero upper byte.
    assign lo = 16'(rdata >> {off, 3'b000});
    assign wstrb = op == OP_SB ? 4'b0001 << off :
                   op == OP_SH ? 4'b0011 << off :
                   op == OP_SW ? 4'b1111 : 4'b0000;
    assign wdata_sh = op == OP_SB ? {4{wdata[7:0]}} :
                      op == OP_SH ? {2{wdata[15:0]}} :
                      op == OP_SW ? wdata : ZERO_WORD;
    assign rdata_ext = op == OP_LB  ? {{24{lo[7]}}, lo[7:0]} :
                       op == OP_LBU ? {24'h0, lo[7:0]} :
                       op == OP_LH  ? {{16{lo[15]}}, lo} :
                       op == OP_LHU ? {16'h0, lo} :
                       op == OP_LW  ? rdata : ZERO_WORD;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences LSU (priority) and IFU accesses onto one memory port, one transaction at a time.
// Define MEM_MISALIGN_CHECK_EN to complete misaligned lh/lhu/sh/lw/sw and fetches with err and no bus access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic [5:0]        ls_op_type,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic              if_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    state_t      state, nxt;
    owner_t      owner;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] wd_cnt;
    logic        ls_mis, if_mis, idle_ok, ls_valid, granted, timeout;
    logic [3:0]  a_wstrb;
    logic [31:0] a_wdata, a_rdata;
`ifdef MEM_MISALIGN_CHECK_EN
    assign ls_mis = ((ls_op_type inside {OP_LH, OP_LHU, OP_SH}) && ls_addr[0]) ||
                    ((ls_op_type inside {OP_LW, OP_SW}) && ls_addr[1:0] != 2'b00);
    assign if_mis = if_addr[1:0] != 2'b00;
`else
    assign ls_mis = 1'b0;
    assign if_mis = 1'b0;
`endif
    // The cycle a done pulse is visible the requester still holds req, so IDLE must not resample it.
    assign idle_ok  = state == IDLE && !if_done && !ls_done;
    assign ls_valid = is_load(ls_op_type) || is_store(ls_op_type);
    assign granted  = mem_req && mem_gnt;
    assign timeout  = TIMEOUT != 0 && wd_cnt == 32'(TIMEOUT - 1);
    mem_lane_align u_align (
        .op        (state == IDLE ? ls_op_type : op_q),
        .off       (state == IDLE ? ls_addr[1:0] : off_q),
        .wdata     (ls_wdata),
        .rdata     (mem_rdata),
        .wstrb     (a_wstrb),
        .wdata_sh  (a_wdata),
        .rdata_ext (a_rdata)
    );
    always_ff @(posedge clk) state <= rst ? IDLE : nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !idle_ok ? IDLE :
                           ls_req   ? (ls_valid && !ls_mis ? ISSUE : DONE) :
                           if_req   ? (if_mis ? DONE : ISSUE) : IDLE;
            ISSUE:   nxt = !granted ? ISSUE : mem_we ? DONE : WAIT;
            WAIT:    nxt = mem_rvalid || timeout ? DONE : WAIT;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_IF;
            op_q      <= '0;
            off_q     <= '0;
            wd_cnt    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_err    <= 1'b0;
            ls_err    <= 1'b0;
        end else begin
            if_done <= state == DONE && owner == OWN_IF;
            ls_done <= state == DONE && owner == OWN_LS;
            mem_req <= state == ISSUE && !granted;
            wd_cnt  <= state == WAIT ? wd_cnt + 32'd1 : '0;
            if (idle_ok && ls_req) begin
                owner     <= OWN_LS;
                op_q      <= ls_op_type;
                off_q     <= ls_addr[1:0];
                mem_addr  <= ls_addr & ~ADDR_W'(3);
                mem_we    <= is_store(ls_op_type) && !ls_mis;
                mem_wdata <= a_wdata;
                mem_wstrb <= a_wstrb;
                ls_rdata  <= ZERO_WORD;
                ls_err    <= ls_mis;
            end else if (idle_ok && if_req) begin
                owner     <= OWN_IF;
                op_q      <= OP_LW;
                off_q     <= 2'b00;
                mem_addr  <= if_addr & ~ADDR_W'(3);
                mem_we    <= 1'b0;
                mem_wdata <= ZERO_WORD;
                mem_wstrb <= 4'b0000;
                if_rdata  <= ZERO_WORD;
                if_err    <= if_mis;
            end
            // rdata was cleared at accept, so a timeout only has to raise err.
            if (state == WAIT && mem_rvalid) begin
                if (owner == OWN_LS) ls_rdata <= a_rdata;
                else if_rdata <= mem_rdata;
            end else if (state == WAIT && timeout) begin
                if (owner == OWN_LS) ls_err <= 1'b1;
                else if_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for mem_port_arbiter.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done, ls_done, ls_err, if_err;
    logic [31:0] if_rdata, ls_rdata;
    logic        ls_req = 1'b0;
    logic [5:0]  ls_op_type = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          lat, dones;
    bit          saw_req, other_done;
    logic        g_we, got_err;
    logic [31:0] g_addr, g_wdata, got_rdata;
    logic [3:0]  g_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_op_type (ls_op_type),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_done    (ls_done),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .if_err     (if_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic ls_go(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
        ls_op_type = op;
        ls_addr    = addr;
        ls_wdata   = wd;
        mem_rdata  = rd;
        ls_req     = 1'b1;
    endtask

    // Bus model: grant once mem_req has been up for `hold` cycles, rvalid the cycle after a read grant.
    task automatic serve(input bit want_if, input bit give_rv, input int hold);
        bit gnt_prev;
        gnt_prev = 1'b0;
        lat = -1;
        saw_req = 1'b0;
        other_done = 1'b0;
        g_we = 1'b0;
        g_addr = '0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            mem_rvalid = gnt_prev && give_rv;
            mem_gnt = mem_req && c >= 2 + hold;
            gnt_prev = mem_gnt;
            if (hold > 0 && c == 3) begin
                ls_addr ^= 32'hFFFF_0000;
                ls_wdata = '0;
            end
            saw_req |= mem_req;
            if (mem_gnt) begin
                g_we = mem_we;
                g_addr = mem_addr;
                g_wdata = mem_wdata;
                g_wstrb = mem_wstrb;
            end
            if (want_if ? ls_done : if_done) other_done = 1'b1;
            if (want_if ? if_done : ls_done) begin
                lat = c;
                got_rdata = want_if ? if_rdata : ls_rdata;
                got_err = want_if ? if_err : ls_err;
            end
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_gnt = 1'b0;
        check("done_pulse_width", 32'(want_if ? if_done : ls_done), 32'h0);
        if (want_if) if_req = 1'b0;
        else ls_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 32'({mem_req, mem_we, mem_wstrb, if_done, ls_done, if_err, ls_err}), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        rst = 1'b0;
        ls_go(OP_SB, 32'h8000_0006, 32'h1234_56AB, 32'h0);
        serve(1'b0, 1'b0, 0);
        check("sb_lat", lat, 4);
        check("sb_strb", 32'(g_wstrb), 32'h4);
        check("sb_wdata", g_wdata, 32'hABAB_ABAB);
        check("sb_addr", g_addr, 32'h8000_0004);
        check("sb_we", 32'(g_we), 32'h1);
        check("sb_rdata", got_rdata, 32'h0);
        ls_go(OP_LB, 32'h8000_0003, 32'h0, 32'h80FF_FFFF);
        serve(1'b0, 1'b1, 0);
        check("lb_lat", lat, 5);
        check("lb_rdata", got_rdata, 32'hFFFF_FF80);
        check("lb_bus", {g_addr[31:1], g_we}, 32'h8000_0000);
        ls_go(OP_LBU, 32'h8000_0003, 32'h0, 32'h80FF_FFFF);
        serve(1'b0, 1'b1, 0);
        check("lbu_rdata", got_rdata, 32'h0000_0080);
        ls_go(OP_LH, 32'h0000_0012, 32'h0, 32'h8001_1234);
        serve(1'b0, 1'b1, 0);
        check("lh_rdata", got_rdata, 32'hFFFF_8001);
        ls_go(OP_LHU, 32'h0000_0013, 32'h0, 32'hAB00_0000);
        serve(1'b0, 1'b1, 0);
        check("lhu_off3_rdata", got_rdata, MIS ? 32'h0 : 32'h0000_00AB);
        check("lhu_off3_err", 32'(got_err), 32'(MIS));
        ls_go(OP_LH, 32'h0000_0013, 32'h0, 32'h8000_0000);
        serve(1'b0, 1'b1, 0);
        check("lh_off3_rdata", got_rdata, MIS ? 32'h0 : 32'h0000_0080);
        ls_go(OP_SH, 32'h0000_0023, 32'hDEAD_BEEF, 32'h0);
        serve(1'b0, 1'b0, 0);
        check("sh_off3_strb", 32'(g_wstrb), MIS ? 32'h0 : 32'h8);
        check("sh_off3_wdata", g_wdata, MIS ? 32'h0 : 32'hBEEF_BEEF);
        check("sh_off3_err", 32'(got_err), 32'(MIS));
        ls_go(OP_SW, 32'h0000_0030, 32'h0123_4567, 32'h0);
        serve(1'b0, 1'b0, 0);
        check("sw_strb", 32'(g_wstrb), 32'hF);
        check("sw_wdata", g_wdata, 32'h0123_4567);
        ls_go(OP_LW, 32'h0000_0002, 32'h0, 32'h0BAD_F00D);
        serve(1'b0, 1'b1, 0);
        check("lw_mis_lat", lat, MIS ? 2 : 5);
        check("lw_mis_req", 32'(saw_req), 32'(!MIS));
        check("lw_mis_strb", 32'(g_wstrb), 32'h0);
        check("lw_mis_rdata", got_rdata, MIS ? 32'h0 : 32'h0BAD_F00D);
        check("lw_mis_err", 32'(got_err), 32'(MIS));
        ls_go(6'h3F, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0);
        serve(1'b0, 1'b0, 0);
        check("nop_lat", lat, 2);
        check("nop_req", 32'(saw_req), 32'h0);
        check("nop_rdata_err", {got_rdata[31:1], got_err}, 32'h0);
        ls_go(OP_SW, 32'h0000_0048, 32'hA5A5_A5A5, 32'h0);
        serve(1'b0, 1'b0, 3);
        check("hold_lat", lat, 7);
        check("hold_addr", g_addr, 32'h0000_0048);
        check("hold_wdata", g_wdata, 32'hA5A5_A5A5);
        ls_go(OP_SW, 32'h0000_0100, 32'h1122_3344, 32'hCAFE_F00D);
        if_addr = 32'h0000_0200;
        if_req = 1'b1;
        serve(1'b0, 1'b0, 0);
        check("arb_ls_lat", lat, 4);
        check("arb_ls_addr", g_addr, 32'h0000_0100);
        check("arb_ls_we", 32'(g_we), 32'h1);
        check("arb_if_waits", 32'(other_done), 32'h0);
        serve(1'b1, 1'b1, 0);
        check("arb_if_lat", lat, 5);
        check("arb_if_addr", g_addr, 32'h0000_0200);
        check("arb_if_we", 32'(g_we), 32'h0);
        check("arb_if_rdata", got_rdata, 32'hCAFE_F00D);
        check("arb_if_err", 32'(got_err), 32'h0);
        ls_go(OP_LW, 32'h0000_0040, 32'h0, 32'h1111_1111);
        serve(1'b0, 1'b0, 0);
        check("to_lat", lat, 20);
        check("to_err", 32'(got_err), 32'h1);
        check("to_rdata", got_rdata, 32'h0);
        mem_rvalid = 1'b1;
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            dones += int'(ls_done | if_done);
        end
        check("late_rvalid_dones", dones, 0);
        ls_go(OP_LW, 32'h0000_0044, 32'h0, 32'h2222_2222);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            mem_gnt = mem_req;
        end
        rst = 1'b1;
        ls_req = 1'b0;
        @(negedge clk);
        check("rst_wait_req", 32'(mem_req), 32'h0);
        check("rst_wait_done", 32'(ls_done), 32'h0);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_gnt = 1'b1;
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_gnt = 1'b0;
            dones += int'(ls_done | if_done | mem_req);
        end
        check("rst_idle_quiet", dones, 0);
        ls_go(OP_LW, 32'h0000_0000, 32'h0, 32'h1357_2468);
        serve(1'b0, 1'b1, 0);
        check("post_rst_lat", lat, 5);
        check("post_rst_rdata", got_rdata, 32'h1357_2468);
        check("post_rst_err", 32'(got_err), 32'h0);
        if_addr = 32'h0000_0006;
        mem_rdata = 32'h55AA_55AA;
        if_req = 1'b1;
        serve(1'b1, 1'b1, 0);
        check("if_mis_lat", lat, MIS ? 2 : 5);
        check("if_mis_addr", g_addr, MIS ? 32'h0 : 32'h0000_0004);
        check("if_mis_rdata", got_rdata, MIS ? 32'h0 : 32'h55AA_55AA);
        check("if_mis_err", 32'(got_err), 32'(MIS));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences every data-memory and instruction-fetch access onto the single shared memory port.
- Arbitrates between the IFU (read-only) and the load/store stage (read/write). Only one transaction is outstanding at a time.
- Generates byte-lane strobes and shifted write data for sb/sh/sw, and performs load alignment with sign/zero extension for lb/lh/lw/lbu/lhu.
- Sits between stage_loadstore/IFU and the memory bus. Its done pulses drive pipeline stalls.

Parameters:
- TIMEOUT, 16: cycles allowed in WAIT before forcing an error completion. 0 disables the watchdog.
- ADDR_W, 32: address width. Data width is fixed at 32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle completion pulse to IFU.
- if_rdata  out  32  fetched word; valid with if_done.
- ls_req  in  1  load/store request; held high until ls_done.
- ls_op_type  in  6  op_type encoding from inst_define.v.
- ls_addr  in  ADDR_W  effective address.
- ls_wdata  in  32  rs2 value, unshifted.
- ls_done  out  1  one-cycle completion pulse to LSU.
- ls_rdata  out  32  extended load result; 0 for stores.
- ls_err  out  1  error qualifier; valid with ls_done.
- if_err  out  1  error qualifier; valid with if_done.
- mem_req  out  1  bus request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- mem_wdata  out  32  lane-shifted write data.
- mem_wstrb  out  4  byte strobes.
- mem_gnt  in  1  bus accepted request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Reset: state=IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_done, ls_done, if_rdata, ls_rdata, if_err, ls_err. Watchdog counter=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If ls_req, latch LSU request, owner=LS.
  - Else if if_req, latch fetch, owner=IF.
  - LSU has fixed priority; simultaneous requests mean LS wins and IF waits.
  - ls_op_type not a load/store: go to DONE with rdata=0, err=0, no bus access.
  - Otherwise go to ISSUE; mem_req rises the next cycle.
- ISSUE:
  - mem_req=1; address/we/wdata/wstrb held stable until mem_gnt.
  - On mem_gnt, mem_req drops next cycle.
  - Write: go to DONE (write is complete at grant).
  - Read: go to WAIT.
- WAIT:
  - On mem_rvalid, capture mem_rdata, extend it, go to DONE.
  - Watchdog increments each WAIT cycle. At TIMEOUT, go to DONE with err=1 and rdata=0.
  - A late mem_rvalid arriving after the timeout is ignored.
- DONE:
  - Pulse the owner's done for exactly one cycle, then go to IDLE.
  - Requester deasserts req in the cycle after done. A re-asserted req is sampled in IDLE.
  - Minimum latency, request to done: 4 cycles for a write with immediate gnt; 5 cycles for a read with rvalid one cycle after gnt.
- Store lanes, off = addr[1:0]:
  - sb: wstrb = 4'b0001<<off; wdata = {4{rs2[7:0]}}.
  - sh: wstrb = 4'b0011<<off, truncated to 4 bits; wdata = {2{rs2[15:0]}}.
  - sw: wstrb = 4'b1111; wdata = rs2.
- Loads:
  - Select byte/halfword at offset off from mem_rdata.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - Halfword at off=3 (check disabled): upper byte reads as 0.
- Fetch: word read; if_rdata = mem_rdata unmodified.
- Reset mid-transaction: next edge returns to IDLE, drops mem_req, and no done pulse is issued. A mem_rvalid or mem_gnt seen in IDLE is ignored.
- Requester inputs are sampled only in IDLE; changes during a transaction have no effect.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, go IDLE->DONE with ls_err=1 and ls_rdata=0, with no bus access.
  - A fetch with if_addr[1:0]!=0 likewise completes with if_err=1.
- Undefined: no alignment check. Lanes are truncated as in Behaviour, and err is driven only by the watchdog.

Decomposition:
- op_type codes and zero_word stay in the shared inst_define.v header.
- Add to that header:
  - FSM state encodings (IDLE/ISSUE/WAIT/DONE), as 2-bit defines.
  - Owner encodings (IF/LS), as 1-bit defines.
- One natural sub-module: mem_lane_align. It is combinational and holds store strobe/data shifting plus load extract/extend. Reused by later cache work.

Test Plan:
- Store sb, addr=0x80000006, rs2=0x123456AB, gnt in ISSUE's first cycle -> mem_wstrb=4'b0100, mem_wdata=0xABABABAB, mem_addr=0x80000004, mem_we=1; ls_done 4 cycles after ls_req.
- Load lb, addr=0x80000003, mem_rdata=0x80FFFFFF -> ls_rdata=0xFFFFFF80. Same access as lbu -> ls_rdata=0x00000080.
- ls_req and if_req asserted the same cycle -> LS served first (mem_we per op); IF issued after ls_done; if_rdata equals the bus word.
- Read with mem_rvalid withheld, TIMEOUT=16 -> ls_done with ls_err=1 and ls_rdata=0 after 16 WAIT cycles; a later rvalid produces no pulse.
- rst asserted during WAIT -> next cycle mem_req=0, state IDLE, no done pulse; a following lw to 0x0 completes normally.
- With MEM_MISALIGN_CHECK_EN, lw at 0x2 -> ls_err=1, mem_req never rises. Without the macro, the same access issues with wstrb unused and returns the word.
